// File: rtl/proj_div_pipe.sv
// Perspective projection of a view-space vertex to screen pixels.
// One shared restoring divider computes x then y quotients, 1 bit per cycle.
module proj_div_pipe #(
   parameter int COORD_W     = 32,
   parameter int FOCAL_SHIFT = 6,
   parameter int SCR_W       = 320,
   parameter int SCR_H       = 180,
   parameter int CLAMP       = 256,
   parameter int NEAR        = 1,
   parameter int OUT_W       = 10,
   parameter int TAG_W       = 8
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [COORD_W-1:0] in_x,
   input  logic signed [COORD_W-1:0] in_y,
   input  logic signed [COORD_W-1:0] in_z,
   input  logic        [TAG_W-1:0]   in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [OUT_W-1:0]   x_screen,
   output logic signed [OUT_W-1:0]   y_screen,
   output logic                      out_onscreen,
   output logic                      out_culled,
   output logic        [TAG_W-1:0]   out_tag
);
   localparam int QW = COORD_W + FOCAL_SHIFT;
   localparam int CW = $clog2(QW);

   typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, OUT} state_t;
   state_t state, state_nxt;

   logic [COORD_W-1:0] z_r, ay_r, rem, rem_nxt;
   logic [QW-1:0]      dvd, q, q_nxt, qx;
   logic [CW-1:0]      cnt;
   logic [COORD_W:0]   rem_sh, trial;
   logic [TAG_W-1:0]   tag_r;
   logic               x_neg, y_neg, culled_r, q_bit;
   logic               accept, cull_in, div_last, onscr;
   int                 cx, cy, x_full, y_full;

   // magnitude as unsigned, so -2^(COORD_W-1) maps to 2^(COORD_W-1) cleanly
   function automatic logic [COORD_W-1:0] absv(input logic signed [COORD_W-1:0] v);
      logic [COORD_W-1:0] u;
      u = v;
      return v[COORD_W-1] ? (~u + 1'b1) : u;
   endfunction

   function automatic int sclamp(input logic [QW-1:0] m, input logic neg);
      int c;
      c = (m > QW'(CLAMP)) ? CLAMP : int'(32'(m));
      return neg ? -c : c;
   endfunction

   assign accept   = in_valid & in_ready;
   assign cull_in  = in_z < NEAR;
   assign div_last = (cnt == CW'(QW - 1));

   always_comb begin
      rem_sh  = {rem, dvd[QW-1]};
      trial   = rem_sh - {1'b0, z_r};
      q_bit   = ~trial[COORD_W];
      rem_nxt = q_bit ? trial[COORD_W-1:0] : rem_sh[COORD_W-1:0];
      q_nxt   = {q[QW-2:0], q_bit};
   end

   always_comb begin
      cx     = sclamp(qx, x_neg);
      cy     = sclamp(q, y_neg);
      x_full = SCR_W / 2 + cx;
      y_full = SCR_H / 2 - cy;
      onscr  = (x_full >= 0) && (x_full < SCR_W) && (y_full >= 0) && (y_full < SCR_H);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = cull_in ? OUT : DIV_X;
         DIV_X:   if (div_last) state_nxt = DIV_Y;
         DIV_Y:   if (div_last) state_nxt = OUT;
         OUT:     if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         x_screen     <= '0;
         y_screen     <= '0;
         out_onscreen <= 1'b0;
         out_culled   <= 1'b0;
         out_tag      <= '0;
         z_r          <= '0;
         ay_r         <= '0;
         rem          <= '0;
         dvd          <= '0;
         q            <= '0;
         qx           <= '0;
         cnt          <= '0;
         tag_r        <= '0;
         x_neg        <= 1'b0;
         y_neg        <= 1'b0;
         culled_r     <= 1'b0;
      end else begin
         in_ready <= (state_nxt == IDLE);
         case (state)
            IDLE: if (accept) begin
               z_r      <= in_z;
               dvd      <= {absv(in_x), {FOCAL_SHIFT{1'b0}}};
               ay_r     <= absv(in_y);
               x_neg    <= in_x[COORD_W-1];
               y_neg    <= in_y[COORD_W-1];
               tag_r    <= in_tag;
               culled_r <= cull_in;
               rem      <= '0;
               cnt      <= '0;
            end
            DIV_X, DIV_Y: begin
               rem <= rem_nxt;
               q   <= q_nxt;
               dvd <= dvd << 1;
               cnt <= cnt + 1'b1;
               if (div_last) begin
                  cnt <= '0;
                  rem <= '0;
                  if (state == DIV_X) begin
                     qx  <= q_nxt;
                     dvd <= {ay_r, {FOCAL_SHIFT{1'b0}}};
                  end
               end
            end
            OUT: begin
               // results register on the first OUT cycle, then hold until taken
               if (!out_valid) begin
                  out_valid    <= 1'b1;
                  out_tag      <= tag_r;
                  out_culled   <= culled_r;
                  x_screen     <= culled_r ? OUT_W'(SCR_W / 2) : OUT_W'(x_full);
                  y_screen     <= culled_r ? OUT_W'(SCR_H / 2) : OUT_W'(y_full);
                  out_onscreen <= culled_r ? 1'b0 : onscr;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_proj_div_pipe.sv
// Directed table-driven bench for proj_div_pipe plus backpressure and reset sequences.
module tb_proj_div_pipe;
   logic               CLK = 1'b0, RESET_N = 1'b0;
   logic               in_valid = 1'b0, out_ready = 1'b0;
   logic               in_ready, out_valid, out_onscreen, out_culled;
   logic signed [31:0] in_x = '0, in_y = '0, in_z = '0;
   logic        [7:0]  in_tag = '0, out_tag;
   logic signed [9:0]  x_screen, y_screen;
   int                 total = 0, bad = 0;

   always #5 CLK = ~CLK;

   proj_div_pipe dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_screen(x_screen), .y_screen(y_screen),
      .out_onscreen(out_onscreen), .out_culled(out_culled), .out_tag(out_tag)
   );

   typedef struct {
      int         x, y, z;
      logic [7:0] tag;
      int         ex, ey;
      logic       eon, ecul;
      int         lat;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   // edges after the accept edge until out_valid is seen, bounded
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge CLK);
         n++;
         @(negedge CLK);
      end while (!out_valid && n < 200);
   endtask

   task automatic send(input int x, input int y, input int z, input logic [7:0] tag);
      in_x = x; in_y = y; in_z = z; in_tag = tag;
      in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   initial begin
      int n, stale;

      vt[0]  = '{20, -10, 40, 8'h5A, 192, 106, 1'b1, 1'b0, 77};
      vt[1]  = '{-7, 5, 3, 8'h01, 11, -16, 1'b0, 1'b0, 77};
      vt[2]  = '{100, 50, 10, 8'h02, 416, -166, 1'b0, 1'b0, 77};
      vt[3]  = '{3, 4, 0, 8'h03, 160, 90, 1'b0, 1'b1, 1};
      vt[4]  = '{3, 4, -5, 8'h04, 160, 90, 1'b0, 1'b1, 1};
      vt[5]  = '{int'(32'h8000_0000), 0, 1, 8'h05, -96, 90, 1'b0, 1'b0, 77};
      vt[6]  = '{0, 0, 1, 8'h06, 160, 90, 1'b1, 1'b0, 77};
      vt[7]  = '{159, 0, 64, 8'h07, 319, 90, 1'b1, 1'b0, 77};
      vt[8]  = '{160, 0, 64, 8'h08, 320, 90, 1'b0, 1'b0, 77};
      vt[9]  = '{0, 91, 64, 8'h09, 160, -1, 1'b0, 1'b0, 77};
      vt[10] = '{-1, 1, 3, 8'hA5, 139, 69, 1'b1, 1'b0, 77};

      repeat (3) @(negedge CLK);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x", x_screen, 0);
      chk("rst_y", y_screen, 0);
      chk("rst_on", out_onscreen, 0);
      chk("rst_cul", out_culled, 0);
      chk("rst_tag", out_tag, 0);
      RESET_N = 1'b1;
      #1 chk("rel_in_ready_pre", in_ready, 0);
      @(negedge CLK);
      chk("rel_in_ready", in_ready, 1);

      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("v%0d_ready", i), in_ready, 1);
         send(vt[i].x, vt[i].y, vt[i].z, vt[i].tag);
         chk($sformatf("v%0d_busy", i), in_ready, 0);
         wait_valid(n);
         chk($sformatf("v%0d_lat", i), n, vt[i].lat);
         chk($sformatf("v%0d_x", i), x_screen, vt[i].ex);
         chk($sformatf("v%0d_y", i), y_screen, vt[i].ey);
         chk($sformatf("v%0d_on", i), out_onscreen, vt[i].eon);
         chk($sformatf("v%0d_cul", i), out_culled, vt[i].ecul);
         chk($sformatf("v%0d_tag", i), out_tag, vt[i].tag);
         @(negedge CLK);
         chk($sformatf("v%0d_done", i), out_valid, 0);
      end

      // backpressure with a second request waiting on in_valid
      out_ready = 1'b0;
      in_x = 1; in_y = 1; in_z = -5; in_tag = 8'h11; in_valid = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      in_z = 0; in_tag = 8'h22;
      @(posedge CLK);
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         chk("bp_valid", out_valid, 1);
         chk("bp_tag", out_tag, 8'h11);
         chk("bp_x", x_screen, 160);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("bp_hs_valid", out_valid, 0);
      chk("bp_hs_in_ready", in_ready, 1);
      chk("bp_hs_tag_hold", out_tag, 8'h11);
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      chk("bp2_busy", in_ready, 0);
      @(posedge CLK);
      @(negedge CLK);
      chk("bp2_valid", out_valid, 1);
      chk("bp2_tag", out_tag, 8'h22);
      chk("bp2_cul", out_culled, 1);
      @(negedge CLK);

      // reset in the middle of the y division
      send(20, -10, 40, 8'h77);
      repeat (50) @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_in_ready", in_ready, 0);
      chk("mr_x", x_screen, 0);
      chk("mr_y", y_screen, 0);
      chk("mr_cul", out_culled, 0);
      chk("mr_tag", out_tag, 0);
      @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1 chk("mr_rel_pre", in_ready, 0);
      @(negedge CLK);
      chk("mr_rel_ready", in_ready, 1);
      stale = 0;
      repeat (100) begin
         @(negedge CLK);
         if (out_valid) stale++;
      end
      chk("mr_stale", stale, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/proj_div_pipe.md
PROJ_DIV_PIPE -- requirements
Module: proj_div_pipe

Interface
REQ-001 SHALL have parameter COORD_W, default 32, signed view-space coordinate width.
REQ-002 SHALL have parameter FOCAL_SHIFT, default 6, focal scale = 2^FOCAL_SHIFT (64).
REQ-003 SHALL have parameter SCR_W, default 320, screen width in pixels.
REQ-004 SHALL have parameter SCR_H, default 180, screen height in pixels.
REQ-005 SHALL have parameter CLAMP, default 256, symmetric NDC clamp magnitude.
REQ-006 SHALL have parameter NEAR, default 1, minimum accepted z.
REQ-007 SHALL have parameter OUT_W, default 10, signed screen coordinate width.
REQ-008 SHALL have parameter TAG_W, default 8, sideband tag width.
REQ-009 SHALL have port CLK, input, 1, sole clock, rising edge.
REQ-010 SHALL have port RESET_N, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-012 SHALL have ports in_x, in_y, in_z, each input, COORD_W, signed view-space vertex.
REQ-013 SHALL have port in_tag, input, TAG_W, opaque tag echoed with the result.
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-015 SHALL have ports x_screen and y_screen, each output, OUT_W, signed screen coordinate.
REQ-016 SHALL have ports out_onscreen (1), out_culled (1) and out_tag (TAG_W), all outputs.

Function
REQ-017 SHALL run FSM states IDLE, DIV_X, DIV_Y, OUT.
REQ-018 SHALL drive in_ready=1 only in IDLE; accept = in_valid & in_ready at a rising edge; accept latches in_x, in_y, in_z and in_tag.
REQ-019 SHALL, on accept with in_z < NEAR (z <= 0 included), go directly to OUT with out_culled=1, x_screen=SCR_W/2, y_screen=SCR_H/2, out_onscreen=0; out_valid rises at edge k+1 (k = accept edge).
REQ-020 SHALL, on accept with in_z >= NEAR, go to DIV_X with out_culled=0.
REQ-021 SHALL compute each quotient with one shared iterative restoring unsigned divider, 1 quotient bit per cycle, QW = COORD_W+FOCAL_SHIFT cycles per quotient; dividend |v|<<FOCAL_SHIFT, divisor z.
REQ-022 SHALL spend exactly QW cycles in DIV_X (x quotient), then QW cycles in DIV_Y (y quotient), then enter OUT; out_valid rises at edge k+2*QW+1 (77 at defaults).
REQ-023 SHALL negate the quotient when the source coordinate is negative, i.e. truncate toward zero; |in_x| = 2^(COORD_W-1) SHALL be handled without overflow.
REQ-024 SHALL clamp each signed quotient q to [-CLAMP, +CLAMP].
REQ-025 SHALL set x_screen = SCR_W/2 + qx and y_screen = SCR_H/2 - qy, computed at full width, then truncated to OUT_W.
REQ-026 SHALL set out_onscreen=1 iff 0 <= x_screen < SCR_W and 0 <= y_screen < SCR_H, evaluated before truncation.
REQ-027 SHALL hold out_valid and all result outputs stable in OUT until out_valid & out_ready; that edge returns to IDLE with out_valid=0.
REQ-028 SHALL not accept new input while in DIV_X, DIV_Y or OUT; no input is dropped or overwritten.
REQ-029 SHALL leave result outputs at their last values in IDLE, DIV_X and DIV_Y; only out_valid qualifies them.

Reset
REQ-030 SHALL, while RESET_N=0, force FSM=IDLE, in_ready=0, out_valid=0, x_screen=0, y_screen=0, out_onscreen=0, out_culled=0, out_tag=0 and divider state=0, regardless of CLK.
REQ-031 SHALL assert in_ready=1 on the first rising edge after RESET_N deasserts; reset during DIV_X, DIV_Y or OUT SHALL abort the operation with no later out_valid for it.

Verification
REQ-032 SHALL cover: x=20, y=-10, z=40, tag=0x5A -> out_valid at k+77, x_screen=192, y_screen=106, onscreen=1, culled=0, tag=0x5A.
REQ-033 SHALL cover: x=-7, y=5, z=3 -> quotients -149 and 106 (truncated toward zero), x_screen=11, y_screen=-16, onscreen=0.
REQ-034 SHALL cover: x=100, y=50, z=10 -> both quotients clamp to 256, x_screen=416, y_screen=-166, onscreen=0.
REQ-035 SHALL cover: z=0, then z=-5 -> each out_valid at k+1, culled=1, x_screen=160, y_screen=90, onscreen=0.
REQ-036 SHALL cover: out_ready held low 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; in_valid held high meanwhile is accepted only on the edge after out_ready=1 completes the handshake.
REQ-037 SHALL cover: RESET_N pulsed low mid-DIV_Y -> all outputs at reset values immediately, in_ready=1 one edge after release, no stale out_valid.
